// File: rtl/decode_scoreboard.sv
// Register scoreboard and forwarding selector for the MIPS decode stage.
// Optional stall counter: define DECODE_SCOREBOARD_PERF_EN to build it.
module decode_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int WB_DEPTH = 3,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rs_addr,
    input  logic              issue_rs_used,
    input  logic [ADDR_W-1:0] issue_rt_addr,
    input  logic              issue_rt_used,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_wr_addr,
    input  logic [CNT_W-1:0]  issue_lat,
    input  logic              hold,
    output logic              stall,
    output logic              issue_fire,
    output logic [CNT_W-1:0]  fwd_rs_stage,
    output logic [CNT_W-1:0]  fwd_rt_stage,
    output logic [31:0]       stall_count
);

    localparam logic [CNT_W-1:0]  WB_MAX     = CNT_W'(WB_DEPTH);
    localparam logic [CNT_W-1:0]  AGE_LAST   = CNT_W'(WB_DEPTH - 1);
    localparam logic [CNT_W-1:0]  AGE_ONE    = CNT_W'(1);
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);
    localparam logic              LOAD_PEND  = (WB_DEPTH > 1);

    logic [NUM_REGS-1:0]             pending_q, pending_d;
    logic [NUM_REGS-1:0][CNT_W-1:0]  age_q, age_d;
    logic [NUM_REGS-1:0][CNT_W-1:0]  lat_q, lat_d;

    logic             rs_pend, rt_pend, rs_blk, rt_blk;
    logic [CNT_W-1:0] eff_lat;
    logic             wr_ok;

    function automatic logic is_tracked(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < NUM_REGS_L);
    endfunction

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        rs_pend = 1'b0;
        rt_pend = 1'b0;
        if (is_tracked(issue_rs_addr)) rs_pend = pending_q[issue_rs_addr];
        if (is_tracked(issue_rt_addr)) rt_pend = pending_q[issue_rt_addr];
        rs_blk = issue_rs_used && rs_pend && (age_q[issue_rs_addr] < lat_q[issue_rs_addr]);
        rt_blk = issue_rt_used && rt_pend && (age_q[issue_rt_addr] < lat_q[issue_rt_addr]);
        fwd_rs_stage = (rs_pend && !rs_blk) ? age_q[issue_rs_addr] : '0;
        fwd_rt_stage = (rt_pend && !rt_blk) ? age_q[issue_rt_addr] : '0;
    end

    assign stall      = issue_valid & (rs_blk | rt_blk);
    assign issue_fire = rst_n & issue_valid & ~stall & ~hold;
    assign wr_ok      = issue_fire & issue_we & is_tracked(issue_wr_addr);

    always_comb begin
        if (issue_lat == '0)         eff_lat = AGE_ONE;
        else if (issue_lat > WB_MAX) eff_lat = WB_MAX;
        else                         eff_lat = issue_lat;
    end

    // Age counts cycles since issue; the issuing edge is the first of them, so
    // a fresh entry reads 1 in the cycle after issue and retires at WB_DEPTH.
    always_comb begin
        pending_d = pending_q;
        age_d     = age_q;
        lat_d     = lat_q;
        if (!hold) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (pending_q[i]) begin
                    if (age_q[i] >= AGE_LAST) begin
                        pending_d[i] = 1'b0;
                        age_d[i]     = '0;
                    end else begin
                        age_d[i] = age_q[i] + AGE_ONE;
                    end
                end
            end
            // The youngest writer overrides same-cycle aging or retire (WAW).
            if (wr_ok) begin
                pending_d[issue_wr_addr] = LOAD_PEND;
                age_d[issue_wr_addr]     = LOAD_PEND ? AGE_ONE : '0;
                lat_d[issue_wr_addr]     = eff_lat;
            end
        end
        pending_d[0] = 1'b0;
    end

    // NOTE: the whole entry array is reset, since a stale pending bit after reset would stall or misforward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            age_q     <= '0;
            lat_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            pending_q <= pending_d;
            age_q     <= age_d;
            lat_q     <= lat_d;
        end
    end

`ifdef DECODE_SCOREBOARD_PERF_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count_q <= '0;
        else if (issue_valid && stall && !hold && (stall_count_q != 32'hFFFF_FFFF))
            stall_count_q <= stall_count_q + 32'd1;
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: timestamp-based reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_decode_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int WB       = 4;
    localparam int CNT_W    = 3;
`ifdef DECODE_SCOREBOARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rs_addr;
    logic              issue_rs_used;
    logic [ADDR_W-1:0] issue_rt_addr;
    logic              issue_rt_used;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_wr_addr;
    logic [CNT_W-1:0]  issue_lat;
    logic              hold;
    logic              stall;
    logic              issue_fire;
    logic [CNT_W-1:0]  fwd_rs_stage;
    logic [CNT_W-1:0]  fwd_rt_stage;
    logic [31:0]       stall_count;

    decode_scoreboard #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .WB_DEPTH(WB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid),
        .issue_rs_addr(issue_rs_addr), .issue_rs_used(issue_rs_used),
        .issue_rt_addr(issue_rt_addr), .issue_rt_used(issue_rt_used),
        .issue_we(issue_we), .issue_wr_addr(issue_wr_addr), .issue_lat(issue_lat),
        .hold(hold),
        .stall(stall), .issue_fire(issue_fire),
        .fwd_rs_stage(fwd_rs_stage), .fwd_rt_stage(fwd_rt_stage),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each register remembers the active-cycle timestamp of its youngest
    // writer; everything else follows from "cycles since issue".
    int          now = 0;
    bit          m_valid [NUM_REGS];
    int          m_t     [NUM_REGS];
    int          m_lat   [NUM_REGS];
    logic [31:0] m_cnt = '0;

    bit u_adv = 1'b0, u_fire = 1'b0, u_inc = 1'b0, u_we = 1'b0;
    int u_wr = 0, u_lat = 1;

    function automatic int eff_lat(input int l);
        return (l == 0) ? 1 : ((l > WB) ? WB : l);
    endfunction

    function automatic bit m_pend(input int r);
        return (r != 0) && m_valid[r] && ((now - m_t[r]) < WB);
    endfunction

    function automatic bit m_blk(input int r, input bit used);
        return used && m_pend(r) && ((now - m_t[r]) < m_lat[r]);
    endfunction

    function automatic int m_fwd(input int r, input bit used);
        return (m_pend(r) && !m_blk(r, used)) ? (now - m_t[r]) : 0;
    endfunction

    always @(negedge clk) begin
        bit e_stall, e_fire;
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) m_valid[i] = 1'b0;
            m_cnt = '0;
        end
        e_stall = issue_valid && (m_blk(int'(issue_rs_addr), issue_rs_used) ||
                                  m_blk(int'(issue_rt_addr), issue_rt_used));
        e_fire  = rst_n && issue_valid && !e_stall && !hold;
        check("model_stall", 32'(stall), 32'(e_stall));
        check("model_fire",  32'(issue_fire), 32'(e_fire));
        check("model_fwd_rs", 32'(fwd_rs_stage), 32'(m_fwd(int'(issue_rs_addr), issue_rs_used)));
        check("model_fwd_rt", 32'(fwd_rt_stage), 32'(m_fwd(int'(issue_rt_addr), issue_rt_used)));
        check("model_stall_count", stall_count, PERF ? m_cnt : 32'd0);
        u_adv  = rst_n && !hold;
        u_fire = e_fire;
        u_inc  = rst_n && issue_valid && e_stall && !hold;
        u_we   = issue_we;
        u_wr   = int'(issue_wr_addr);
        u_lat  = eff_lat(int'(issue_lat));
    end

    always @(posedge clk) begin
        if (rst_n && u_adv) begin
            if (u_fire && u_we && u_wr != 0) begin
                m_valid[u_wr] = 1'b1;
                m_t[u_wr]     = now;
                m_lat[u_wr]   = u_lat;
            end
            now++;
            if (u_inc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic step(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic we,
                        input logic [4:0] wr, input logic [2:0] lat, input logic hd);
        @(posedge clk);
        #1;
        issue_valid = v;  issue_rs_addr = rs; issue_rs_used = rsu;
        issue_rt_addr = rt; issue_rt_used = rtu;
        issue_we = we; issue_wr_addr = wr; issue_lat = lat; hold = hd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0;
        issue_valid = 1'b1; issue_rs_addr = 5'd8; issue_rs_used = 1'b1;
        issue_rt_addr = '0; issue_rt_used = 1'b0;
        issue_we = 1'b0; issue_wr_addr = '0; issue_lat = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_fire", 32'(issue_fire), 32'd0);
        check("reset_fwd_rs", 32'(fwd_rs_stage), 32'd0);
        check("reset_stall_count", stall_count, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // ADDU $8 (lat 1) then a reader of $8
        step(1, 0, 0, 0, 0, 1, 8, 1, 0);  check("first_issue_fire", 32'(issue_fire), 32'd1);
        step(1, 8, 1, 0, 0, 0, 0, 0, 0);  check("alu_stall", 32'(stall), 32'd0);
                                          check("alu_fwd_rs", 32'(fwd_rs_stage), 32'd1);
        // LW $9 (lat 2), reader in rt
        step(1, 0, 0, 0, 0, 1, 9, 2, 0);
        step(1, 0, 0, 9, 1, 0, 0, 0, 0);  check("lw_stall", 32'(stall), 32'd1);
                                          check("lw_fire0", 32'(issue_fire), 32'd0);
        step(1, 0, 0, 9, 1, 0, 0, 0, 0);  check("lw_fire", 32'(issue_fire), 32'd1);
                                          check("lw_fwd_rt", 32'(fwd_rt_stage), 32'd2);
                                          check("lw_stall_count", stall_count, PERF ? 32'd1 : 32'd0);
        // MUL $10 (lat 3), WB_DEPTH 4
        step(1, 0, 0, 0, 0, 1, 10, 3, 0);
        step(1, 10, 1, 0, 0, 0, 0, 0, 0); check("mul_stall1", 32'(stall), 32'd1);
        step(1, 10, 1, 0, 0, 0, 0, 0, 0); check("mul_stall2", 32'(stall), 32'd1);
        step(1, 10, 1, 0, 0, 0, 0, 0, 0); check("mul_fire", 32'(issue_fire), 32'd1);
                                          check("mul_fwd_rs", 32'(fwd_rs_stage), 32'd3);
        step(0, 10, 1, 0, 0, 0, 0, 0, 0); check("mul_retired_fwd", 32'(fwd_rs_stage), 32'd0);
        // WAW on $11: LW then ADDU, reader sees the ADDU
        step(1, 0, 0, 0, 0, 1, 11, 2, 0);
        step(1, 0, 0, 0, 0, 1, 11, 1, 0);
        step(1, 11, 1, 0, 0, 0, 0, 0, 0); check("waw_stall", 32'(stall), 32'd0);
                                          check("waw_fwd_rs", 32'(fwd_rs_stage), 32'd1);
        // write to $0 never creates a hazard
        step(1, 0, 0, 0, 0, 1, 0, 2, 0);
        step(1, 0, 1, 0, 1, 0, 0, 0, 0);  check("r0_stall", 32'(stall), 32'd0);
                                          check("r0_fwd_rs", 32'(fwd_rs_stage), 32'd0);
                                          check("r0_fwd_rt", 32'(fwd_rt_stage), 32'd0);
        // hazard on $13 frozen by hold for 3 cycles
        step(1, 0, 0, 0, 0, 1, 13, 3, 0);
        step(1, 13, 1, 0, 0, 0, 0, 0, 1); check("hold_stall", 32'(stall), 32'd1);
                                          check("hold_fire1", 32'(issue_fire), 32'd0);
        step(1, 13, 1, 0, 0, 0, 0, 0, 1); check("hold_fire2", 32'(issue_fire), 32'd0);
        step(1, 13, 1, 0, 0, 0, 0, 0, 1); check("hold_fire3", 32'(issue_fire), 32'd0);
                                          check("hold_stall_count", stall_count, PERF ? 32'd3 : 32'd0);
        step(1, 13, 1, 0, 0, 0, 0, 0, 0); check("post_hold_stall1", 32'(stall), 32'd1);
        step(1, 13, 1, 0, 0, 0, 0, 0, 0); check("post_hold_stall2", 32'(stall), 32'd1);
        step(1, 13, 1, 0, 0, 0, 0, 0, 0); check("post_hold_fwd", 32'(fwd_rs_stage), 32'd3);
                                          check("post_hold_count", stall_count, PERF ? 32'd5 : 32'd0);
        // latency clamping: 0 acts as 1, 7 acts as WB_DEPTH
        step(1, 0, 0, 0, 0, 1, 14, 0, 0);
        step(1, 14, 1, 0, 0, 0, 0, 0, 0); check("lat0_stall", 32'(stall), 32'd0);
                                          check("lat0_fwd", 32'(fwd_rs_stage), 32'd1);
        step(1, 0, 0, 0, 0, 1, 15, 7, 0);
        step(1, 0, 0, 15, 1, 0, 0, 0, 0);
        step(1, 0, 0, 15, 1, 0, 0, 0, 0);
        step(1, 0, 0, 15, 1, 0, 0, 0, 0); check("lat7_stall3", 32'(stall), 32'd1);
        step(1, 0, 0, 15, 1, 0, 0, 0, 0); check("lat7_retired_stall", 32'(stall), 32'd0);
                                          check("lat7_retired_fwd", 32'(fwd_rt_stage), 32'd0);
        // self-read: own write affects only later readers
        step(1, 16, 1, 0, 0, 1, 16, 2, 0); check("self_read_fire", 32'(issue_fire), 32'd1);
        step(1, 16, 1, 0, 0, 0, 0, 0, 0);  check("self_read_next", 32'(stall), 32'd1);
        // reset while $12 is pending
        step(1, 0, 0, 0, 0, 1, 12, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0; issue_valid = 1'b1; issue_rs_addr = 5'd12; issue_rs_used = 1'b1;
        @(negedge clk); #1;
        check("mid_reset_stall", 32'(stall), 32'd0);
        check("mid_reset_fire", 32'(issue_fire), 32'd0);
        check("mid_reset_fwd", 32'(fwd_rs_stage), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check("after_reset_stall", 32'(stall), 32'd0);
        check("after_reset_fwd", 32'(fwd_rs_stage), 32'd0);
        check("after_reset_fire", 32'(issue_fire), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
